// File: rtl/charge_pkg.sv
// charge_pkg: shared state codes, coin mode constants and coin-value decode for the charging station.
package charge_pkg;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CREDIT   = 3'd1,
        S_CHARGING = 3'd2,
        S_PAUSED   = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [3:0] MODE_1P = 4'b0001;
    localparam logic [3:0] MODE_5P = 4'b0101;

    function automatic logic [7:0] coin_value(input logic [3:0] mode);
        return mode == MODE_1P ? 8'd1 : mode == MODE_5P ? 8'd5 : 8'd0;
    endfunction
endpackage

// File: rtl/charge_session_ctrl_sec_tick_gen.sv
// sec_tick_gen: counts CLK_HZ cycles and fires a one-cycle tick; clear resets the count, hold freezes it.
module sec_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic nReset,
    input  logic clear_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = !clear_i && !hold_i && cnt_q == CW'(CLK_HZ - 1);
        cnt_d  = (clear_i || tick_o) ? '0 : hold_i ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/charge_session_ctrl.sv
// charge_session_ctrl: coin credit to charging time, relay drive and per-second countdown.
// Build option UNPLUG_PAUSE_EN: unplugging pauses the session instead of ending it.
module charge_session_ctrl
    import charge_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SEC_PER_PESO = 60,
    parameter int MAX_CREDIT   = 99,
    parameter int TIME_W       = 16
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              coin_valid_i,
    input  logic [3:0]        coin_mode_i,
    input  logic              plug_in_i,
    input  logic              start_i,
    input  logic              cancel_i,
    output logic              coin_accept_o,
    output logic              relay_on_o,
    output logic [2:0]        state_o,
    output logic [6:0]        credit_o,
    output logic [TIME_W-1:0] time_left_o,
    output logic              done_o,
    output logic              coin_reject_o
);
`ifdef UNPLUG_PAUSE_EN
    localparam logic PAUSE_EN = 1'b1;
`else
    localparam logic PAUSE_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [6:0]        credit_q, credit_d, credit_tot;
    logic [TIME_W-1:0] time_q, time_d;
    logic [7:0]        coin_val, coin_sum;
    logic              coin_ok, tick, finish;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .nReset  (nReset),
        .clear_i (state_q != S_CHARGING && state_q != S_PAUSED),
        .hold_i  (state_q == S_PAUSED),
        .tick_o  (tick)
    );

    always_comb begin
        coin_val   = coin_value(coin_mode_i);
        coin_sum   = {1'b0, credit_q} + coin_val;
        coin_ok    = coin_valid_i && coin_val != 8'd0 && coin_sum <= 8'(MAX_CREDIT)
                     && (state_q == S_IDLE || state_q == S_CREDIT);
        credit_tot = coin_ok ? coin_sum[6:0] : credit_q;
        finish     = cancel_i || (tick && time_q == TIME_W'(1));
        state_d    = state_q;
        credit_d   = credit_q;
        time_d     = time_q;
        case (state_q)
            S_IDLE: begin
                credit_d = credit_tot;
                if (coin_ok) state_d = S_CREDIT;
            end
            S_CREDIT: begin
                credit_d = credit_tot;
                if (start_i && plug_in_i && credit_tot != 7'd0) begin
                    state_d  = S_CHARGING;
                    credit_d = '0;
                    time_d   = TIME_W'(credit_tot) * TIME_W'(SEC_PER_PESO);
                end
            end
            S_CHARGING: begin
                if (tick) time_d = time_q - TIME_W'(1);
                // Without pause support an unplug ends the session exactly like cancel
                if (finish || (!PAUSE_EN && !plug_in_i)) begin
                    state_d = S_DONE;
                    time_d  = '0;
                end else if (!plug_in_i) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (cancel_i) begin
                    state_d = S_DONE;
                    time_d  = '0;
                end else if (plug_in_i) begin
                    state_d = S_CHARGING;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            time_q        <= '0;
            relay_on_o    <= 1'b0;
            coin_accept_o <= 1'b1;
            done_o        <= 1'b0;
            coin_reject_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            time_q        <= time_d;
            relay_on_o    <= state_d == S_CHARGING;
            coin_accept_o <= state_d == S_IDLE || state_d == S_CREDIT;
            done_o        <= state_d == S_DONE;
            coin_reject_o <= coin_valid_i && !coin_ok;
        end
    end

    assign state_o     = state_q;
    assign credit_o    = credit_q;
    assign time_left_o = time_q;
endmodule

// File: tb/tb_charge_session_ctrl.sv
// tb_charge_session_ctrl: directed scoreboard bench; expectations queued with each stimulus step.
module tb_charge_session_ctrl;
    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        coin_valid = 1'b0;
    logic [3:0]  coin_mode = 4'b0000;
    logic        plug_in = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        coin_accept, relay_on, done, coin_reject;
    logic [2:0]  state;
    logic [6:0]  credit;
    logic [15:0] time_left;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    charge_session_ctrl #(
        .CLK_HZ(10), .SEC_PER_PESO(2), .MAX_CREDIT(99), .TIME_W(16)
    ) dut (
        .clk           (clk),
        .nReset        (nReset),
        .coin_valid_i  (coin_valid),
        .coin_mode_i   (coin_mode),
        .plug_in_i     (plug_in),
        .start_i       (start),
        .cancel_i      (cancel),
        .coin_accept_o (coin_accept),
        .relay_on_o    (relay_on),
        .state_o       (state),
        .credit_o      (credit),
        .time_left_o   (time_left),
        .done_o        (done),
        .coin_reject_o (coin_reject)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(string t);
        case (t)
            "state":  return 32'(state);
            "credit": return 32'(credit);
            "time":   return 32'(time_left);
            "relay":  return 32'(relay_on);
            "accept": return 32'(coin_accept);
            "done":   return 32'(done);
            "reject": return 32'(coin_reject);
            default:  return 'x;
        endcase
    endfunction

    task automatic ex(string t, logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    // Advance n cycles, drop one-cycle strobes, then compare every queued expectation.
    task automatic go(int n);
        exp_t        e;
        logic [31:0] obs;
        repeat (n) begin
            @(posedge clk);
            #1;
            coin_valid = 1'b0;
            start = 1'b0;
            cancel = 1'b0;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic coin(logic [3:0] m);
        coin_valid = 1'b1;
        coin_mode = m;
    endtask

    task automatic reset_vals();
        ex("state", 0); ex("credit", 0); ex("time", 0); ex("relay", 0);
        ex("accept", 1); ex("done", 0); ex("reject", 0);
    endtask

    initial begin
        reset_vals();
        go(2);
        nReset = 1'b1;
        plug_in = 1'b1;

        coin(4'b0001); ex("credit", 1); ex("state", 1); ex("accept", 1); go(1);
        coin(4'b0101); ex("credit", 6); go(1);
        start = 1'b1;
        ex("state", 2); ex("time", 12); ex("relay", 1); ex("credit", 0); ex("accept", 0); go(1);
        ex("time", 11); go(10);
        coin(4'b0001); ex("reject", 1); ex("time", 11); ex("credit", 0); go(1);
        ex("time", 1); ex("state", 2); go(108);
        ex("state", 4); ex("time", 0); ex("relay", 0); ex("done", 1); go(1);
        ex("state", 0); ex("done", 0); ex("accept", 1); go(1);

        repeat (19) begin coin(4'b0101); go(1); end
        ex("credit", 95); go(0);
        coin(4'b0001); go(1);
        coin(4'b0001); ex("credit", 97); go(1);
        coin(4'b0101); ex("reject", 1); ex("credit", 97); go(1);
        coin(4'b0001); ex("reject", 0); ex("credit", 98); go(1);
        coin(4'b0001); ex("credit", 99); go(1);
        coin(4'b0001); ex("reject", 1); ex("credit", 99); go(1);
        cancel = 1'b1; ex("state", 1); ex("credit", 99); go(1);
        plug_in = 1'b0;
        start = 1'b1; ex("state", 1); ex("relay", 0); go(1);
        plug_in = 1'b1;
        start = 1'b1; ex("state", 2); ex("time", 198); ex("credit", 0); go(1);
        cancel = 1'b1; ex("state", 4); ex("time", 0); ex("done", 1); ex("relay", 0); go(1);
        ex("state", 0); go(1);

        coin(4'b0001); ex("credit", 1); go(1);
        coin(4'b0101); start = 1'b1;
        ex("state", 2); ex("time", 12); ex("credit", 0); ex("reject", 0); go(1);
        ex("time", 3); ex("state", 2); go(90);
        cancel = 1'b1; ex("state", 4); ex("relay", 0); ex("time", 0); ex("done", 1); go(1);
        ex("state", 0); ex("done", 0); go(1);
        ex("done", 0); go(1);

        coin(4'b0101); ex("credit", 5); go(1);
        start = 1'b1; ex("time", 10); go(1);
        ex("time", 6); go(49);
        plug_in = 1'b0;
`ifdef UNPLUG_PAUSE_EN
        ex("state", 3); ex("relay", 0); ex("time", 5); ex("accept", 0); go(1);
        ex("state", 3); ex("time", 5); go(20);
        plug_in = 1'b1;
        ex("state", 2); ex("relay", 1); ex("time", 5); go(1);
        ex("state", 2); ex("time", 1); go(49);
        ex("state", 4); ex("done", 1); ex("time", 0); ex("relay", 0); go(1);
`else
        ex("state", 4); ex("time", 0); ex("relay", 0); ex("done", 1); go(1);
        plug_in = 1'b1;
`endif
        ex("state", 0); ex("done", 0); go(1);

        coin(4'b0001); go(1);
        start = 1'b1; ex("state", 2); ex("time", 2); go(1);
        go(3);
        nReset = 1'b0;
        reset_vals();
        go(1);
        nReset = 1'b1;
        coin(4'b0011); ex("reject", 1); ex("state", 0); ex("credit", 0); ex("accept", 1); go(1);
        ex("reject", 0); go(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/charge_session_ctrl.md
# charge_session_ctrl

Coin-operated charging session controller for the charging station. It takes decoded coin events from the coin mode selector, accumulates credit in pesos, and converts the credit into charging time on start. It drives the charger relay and counts the session down in whole seconds. It also gates coin acceptance and reports session completion to the display and top level.

## Interface
- CLK_HZ, 50_000_000, clock cycles per second tick
- SEC_PER_PESO, 60, seconds of charging bought by one peso
- MAX_CREDIT, 99, credit ceiling in pesos
- TIME_W, 16, width of time_left; must hold MAX_CREDIT*SEC_PER_PESO
- clk  in  1  system clock, all logic rising-edge
- nReset  in  1  reset nReset, synchronous, active-low
- coin_valid  in  1  one-cycle strobe, coin_mode valid
- coin_mode  in  4  0001 = 1 peso, 0101 = 5 peso, other codes invalid
- plug_in  in  1  device connected (already synchronised)
- start  in  1  one-cycle start request
- cancel  in  1  one-cycle abort request
- coin_accept  out  1  enable to coin selector; 1 in IDLE/CREDIT only
- relay_on  out  1  charger relay drive
- state  out  3  current FSM state code
- credit  out  7  accumulated pesos
- time_left  out  TIME_W  remaining seconds
- done  out  1  one-cycle pulse at session end
- coin_reject  out  1  one-cycle pulse, coin refused

## Operation
- States: IDLE=0, CREDIT=1, CHARGING=2, PAUSED=3, DONE=4.
- IDLE: credit=0, time_left=0. A valid coin (valid code, credit+value ≤ MAX_CREDIT) adds its value and moves to CREDIT.
- Invalid coin_mode with coin_valid: coin_reject pulse, no change, any state.
- CREDIT: valid coins accumulate. A coin that would exceed MAX_CREDIT gives coin_reject and leaves credit unchanged. cancel is ignored (no refund path).
- CREDIT → CHARGING when start && plug_in && (credit+accepted coin this cycle) > 0. Load time_left = total*SEC_PER_PESO. Clear credit. start without plug_in is ignored.
- Coin and start in the same cycle: the coin is accepted if within limit and included in the loaded time.
- CHARGING: relay_on=1, coin_accept=0. Any coin_valid gives coin_reject. time_left decrements by 1 on each second tick.
- CHARGING → DONE when a tick takes time_left to 0, or on cancel (remaining time forfeited, time_left cleared). Cancel and final tick in the same cycle go to DONE once.
- Unplug in CHARGING: behaviour per Configuration.
- DONE: relay_on=0, done=1 for exactly this cycle, then IDLE.
- Reset values: state=IDLE, credit=0, time_left=0, relay_on=0, coin_accept=1, done=0, coin_reject=0, tick counter=0.
- Reset mid-session: relay drops in the cycle after nReset is sampled low. Credit and time are lost.

## Timing
- All outputs are registered.
- coin → credit update: 1 cycle.
- start sampled → relay_on=1 and time_left loaded on the next edge.
- Tick counter clears on entry to CHARGING. The first decrement occurs exactly CLK_HZ cycles after entry, then every CLK_HZ cycles.
- The tick counter holds while PAUSED and resumes from its held value.
- Final tick → DONE state and relay_on=0 on the same edge. done pulse during DONE, IDLE the cycle after.
- Arithmetic: credit+value computed 8 bits wide before the limit compare. The product is TIME_W wide; no overflow given the parameter rule.

## Configuration
- UNPLUG_PAUSE_EN defined:
  - plug_in=0 in CHARGING → PAUSED, relay_on=0, time_left held.
  - plug_in=1 in PAUSED → CHARGING.
  - cancel in PAUSED → DONE.
- UNPLUG_PAUSE_EN undefined:
  - plug_in=0 in CHARGING → DONE, with the same effect as cancel.
  - The PAUSED state is unreachable and its code is unused.

## Structure
- Shared package charge_pkg holds:
  - state enum codes
  - coin mode constants (MODE_1P=4'b0001, MODE_5P=4'b0101)
  - a coin-value decode function: mode → pesos, 0 if invalid
- Sub-module sec_tick_gen provides:
  - CLK_HZ counter with clear and hold inputs
  - one-cycle tick output

## Test plan
- CLK_HZ=10, SEC_PER_PESO=2. Coins 1P then 5P, start with plug_in=1 → credit 6, time_left 12, relay_on next cycle, done after 120 cycles.
- credit=97, insert 5P → coin_reject, credit stays 97. Insert 1P → credit 98.
- Coin 5P and start in the same cycle from credit=1 → time_left=12.
- Charging at time_left=3, pulse cancel → DONE next edge, relay_on=0, time_left=0, single done pulse.
- Unplug at time_left=5:
  - with UNPLUG_PAUSE_EN: PAUSED holds 5; replug resumes and ends 50 cycles later
  - without it: DONE immediately
- nReset low during CHARGING → all outputs at reset values next cycle. Coin 0011 in IDLE → coin_reject, state IDLE.
